// File: rtl/traffic_light_ctrl_pkg.sv
// Shared encodings for the traffic light controller: phase codes and the
// per-approach {red,yellow,green} light codes.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10,
        PH_FLASH  = 2'b11
    } phase_t;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Request/timing inputs and light outputs of the intersection controller,
// bundled so the controller and its environment share one connection.
interface traffic_light_ctrl_if
    import traffic_pkg::*;
#(
    parameter int N_WAY = 4,
    parameter int CNT_W = 6
);
    localparam int WAY_W = $clog2(N_WAY);

    logic [N_WAY-1:0]   demand;
    logic               flash_mode;
    logic [CNT_W-1:0]   green_time;
    logic [CNT_W-1:0]   yellow_time;
    logic [3*N_WAY-1:0] lights;
    logic [WAY_W-1:0]   cur_way;
    phase_t             phase;

    modport master (
        output demand, flash_mode, green_time, yellow_time,
        input  lights, cur_way, phase
    );

    modport slave (
        input  demand, flash_mode, green_time, yellow_time,
        output lights, cur_way, phase
    );

endinterface

// File: rtl/traffic_light_ctrl_rr_next_sel.sv
// Round-robin search for the next approach with demand, starting just after
// the current one and never selecting the current approach itself.
module rr_next_sel
    import traffic_pkg::*;
#(
    parameter int N_WAY = 4,
    localparam int WAY_W = $clog2(N_WAY)
) (
    input  logic [N_WAY-1:0] demand,
    input  logic [WAY_W-1:0] cur_way,
    output logic             found,
    output logic [WAY_W-1:0] next_way
);

    logic [WAY_W:0]   sum;
    logic [WAY_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        found    = 1'b0;
        next_way = '0;
        sum      = '0;
        idx      = '0;
        for (int k = N_WAY - 1; k >= 1; k--) begin
            sum = {1'b0, cur_way} + (WAY_W + 1)'(k);
            if (sum >= (WAY_W + 1)'(N_WAY)) begin
                sum = sum - (WAY_W + 1)'(N_WAY);
            end
            idx = sum[WAY_W-1:0];
            if (demand[idx]) begin
                found    = 1'b1;
                next_way = idx;
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Demand-driven round-robin traffic light controller with yellow and all-red
// clearance phases and an overriding flashing-yellow mode.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int N_WAY    = 4,
    parameter int CNT_W    = 6,
    parameter int ALLRED_T = 1,
    parameter int FLASH_T  = 4
) (
    input  logic clk,
    input  logic reset,
    traffic_light_ctrl_if.slave bus
);

    localparam int WAY_W = $clog2(N_WAY);
    localparam logic [CNT_W-1:0] ALLRED_CNT = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] FLASH_CNT  = CNT_W'(FLASH_T);

    phase_t             phase_q, phase_d;
    logic [WAY_W-1:0]   cur_way_q, cur_way_d;
    logic [WAY_W-1:0]   next_q, next_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   g_dur_q, g_dur_d;
    logic [CNT_W-1:0]   y_dur_q, y_dur_d;
    logic [CNT_W-1:0]   g_eff;
    logic               flash_on_q, flash_on_d;
    logic               g_pend_q;
    logic               sel_found;
    logic [WAY_W-1:0]   sel_next;
    logic [3*N_WAY-1:0] lights_v;

    function automatic logic [CNT_W-1:0] fix_dur(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    rr_next_sel #(.N_WAY(N_WAY)) u_sel (
        .demand   (bus.demand),
        .cur_way  (cur_way_q),
        .found    (sel_found),
        .next_way (sel_next)
    );

    // Reset holds no sampled green yet; the first cycle reads green_time live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= PH_GREEN;
            cur_way_q  <= '0;
            next_q     <= '0;
            count_q    <= CNT_W'(1);
            g_dur_q    <= CNT_W'(1);
            y_dur_q    <= CNT_W'(1);
            flash_on_q <= 1'b1;
            g_pend_q   <= 1'b1;
        end else begin
            phase_q    <= phase_d;
            cur_way_q  <= cur_way_d;
            next_q     <= next_d;
            count_q    <= count_d;
            g_dur_q    <= g_dur_d;
            y_dur_q    <= y_dur_d;
            flash_on_q <= flash_on_d;
            g_pend_q   <= 1'b0;
        end
    end

    // Flash request is checked before any phase expiry so it always wins.
    always_comb begin
        phase_d    = phase_q;
        cur_way_d  = cur_way_q;
        next_d     = next_q;
        count_d    = count_q + CNT_W'(1);
        g_dur_d    = g_dur_q;
        y_dur_d    = y_dur_q;
        flash_on_d = flash_on_q;
        g_eff      = g_pend_q ? fix_dur(bus.green_time) : g_dur_q;
        if (g_pend_q) begin
            g_dur_d = fix_dur(bus.green_time);
        end

        if (bus.flash_mode) begin
            if (phase_q != PH_FLASH) begin
                phase_d    = PH_FLASH;
                count_d    = CNT_W'(1);
                flash_on_d = 1'b1;
            end else if (count_q >= FLASH_CNT) begin
                count_d    = CNT_W'(1);
                flash_on_d = ~flash_on_q;
            end
        end else begin
            unique case (phase_q)
                PH_GREEN: begin
                    if (count_q >= g_eff) begin
                        count_d = CNT_W'(1);
                        if (sel_found) begin
                            phase_d = PH_YELLOW;
                            next_d  = sel_next;
                            y_dur_d = fix_dur(bus.yellow_time);
                        end else begin
                            g_dur_d = fix_dur(bus.green_time);
                        end
                    end
                end
                PH_YELLOW: begin
                    if (count_q >= y_dur_q) begin
                        phase_d = PH_ALLRED;
                        count_d = CNT_W'(1);
                    end
                end
                PH_ALLRED: begin
                    if (count_q >= ALLRED_CNT) begin
                        phase_d   = PH_GREEN;
                        cur_way_d = next_q;
                        count_d   = CNT_W'(1);
                        g_dur_d   = fix_dur(bus.green_time);
                    end
                end
                PH_FLASH: begin
                    phase_d = PH_ALLRED;
                    next_d  = '0;
                    count_d = CNT_W'(1);
                end
            endcase
        end
    end

    always_comb begin
        lights_v = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (phase_q == PH_FLASH) begin
                lights_v[3*i +: 3] = flash_on_q ? LIGHT_YELLOW : LIGHT_OFF;
            end else if (phase_q == PH_GREEN && cur_way_q == WAY_W'(i)) begin
                lights_v[3*i +: 3] = LIGHT_GREEN;
            end else if (phase_q == PH_YELLOW && cur_way_q == WAY_W'(i)) begin
                lights_v[3*i +: 3] = LIGHT_YELLOW;
            end else begin
                lights_v[3*i +: 3] = LIGHT_RED;
            end
        end
    end

    assign bus.lights  = lights_v;
    assign bus.cur_way = cur_way_q;
    assign bus.phase   = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed-stimulus bench for traffic_light_ctrl: a countdown-based model of
// the signal plan is compared every cycle, plus hand-computed checkpoints.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int N = 4;
    localparam int FT = 4;
    localparam int AT = 1;
    localparam int P_GREEN = 0, P_YELLOW = 1, P_ALLRED = 2, P_FLASH = 3;

    localparam logic [11:0] L_W0G = 12'b100_100_100_001;
    localparam logic [11:0] L_W0Y = 12'b100_100_100_010;
    localparam logic [11:0] L_W1G = 12'b100_100_001_100;
    localparam logic [11:0] L_W2G = 12'b100_001_100_100;
    localparam logic [11:0] L_RED = 12'b100_100_100_100;
    localparam logic [11:0] L_FON = 12'b010_010_010_010;
    localparam logic [11:0] L_OFF = 12'b000_000_000_000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    int m_phase, m_way, m_next, m_left;
    bit m_lit, m_gpend;

    traffic_light_ctrl_if #(.N_WAY(N), .CNT_W(6)) bus ();

    traffic_light_ctrl #(
        .N_WAY(N), .CNT_W(6), .ALLRED_T(AT), .FLASH_T(FT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int fixd(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_phase = P_GREEN;
        m_way   = 0;
        m_next  = 0;
        m_left  = 1;
        m_lit   = 1'b1;
        m_gpend = 1'b1;
    endtask

    // m_left counts the cycles still remaining in the current phase.
    task automatic model_step();
        int nxt;
        if (m_gpend) begin
            m_left  = fixd(int'(bus.green_time));
            m_gpend = 1'b0;
        end
        if (bus.flash_mode) begin
            if (m_phase != P_FLASH) begin
                m_phase = P_FLASH;
                m_lit   = 1'b1;
                m_left  = FT;
            end else if (m_left == 1) begin
                m_lit  = !m_lit;
                m_left = FT;
            end else begin
                m_left--;
            end
        end else if (m_phase == P_FLASH) begin
            m_phase = P_ALLRED;
            m_next  = 0;
            m_left  = AT;
        end else if (m_left > 1) begin
            m_left--;
        end else begin
            case (m_phase)
                P_GREEN: begin
                    nxt = -1;
                    for (int k = 1; k < N; k++) begin
                        if (nxt < 0 && ((bus.demand >> ((m_way + k) % N)) & 4'b1) != 4'b0) begin
                            nxt = (m_way + k) % N;
                        end
                    end
                    if (nxt >= 0) begin
                        m_next  = nxt;
                        m_phase = P_YELLOW;
                        m_left  = fixd(int'(bus.yellow_time));
                    end else begin
                        m_left = fixd(int'(bus.green_time));
                    end
                end
                P_YELLOW: begin
                    m_phase = P_ALLRED;
                    m_left  = AT;
                end
                default: begin
                    m_phase = P_GREEN;
                    m_way   = m_next;
                    m_left  = fixd(int'(bus.green_time));
                end
            endcase
        end
    endtask

    function automatic logic [11:0] model_lights();
        logic [11:0] l;
        logic [11:0] code;
        l = '0;
        for (int i = 0; i < N; i++) begin
            if (m_phase == P_FLASH) code = m_lit ? 12'b010 : 12'b000;
            else if (i == m_way && m_phase == P_GREEN) code = 12'b001;
            else if (i == m_way && m_phase == P_YELLOW) code = 12'b010;
            else code = 12'b100;
            l = l | (code << (3 * i));
        end
        return l;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // Every falling edge: DUT outputs must match the model.
    initial begin
        forever begin
            @(negedge clk);
            total++;
            if (bus.lights !== model_lights() || bus.phase !== 2'(m_phase) ||
                ((m_phase == P_GREEN || m_phase == P_YELLOW) && bus.cur_way !== 2'(m_way))) begin
                bad++;
                $display("[TB] FAIL model_cmp t=%0t got lights=%b phase=%b way=%0d want lights=%b phase=%0d way=%0d",
                         $time, bus.lights, bus.phase, bus.cur_way, model_lights(), m_phase, m_way);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] d, input logic f,
                                 input logic [5:0] g, input logic [5:0] y);
        bus.demand      = d;
        bus.flash_mode  = f;
        bus.green_time  = g;
        bus.yellow_time = y;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] exp_l,
                               input int exp_p, input int exp_w);
        total++;
        if (bus.lights !== exp_l || bus.phase !== 2'(exp_p) ||
            (exp_w >= 0 && bus.cur_way !== 2'(exp_w))) begin
            bad++;
            $display("[TB] FAIL %s got lights=%b phase=%b way=%0d want lights=%b phase=%0d way=%0d",
                     name, bus.lights, bus.phase, bus.cur_way, exp_l, exp_p, exp_w);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
    endtask

    initial begin
        applyStimulus(4'b1111, 1'b0, 6'd8, 6'd3);
        wait_cycles(3);
        checkOutput("in_reset", L_W0G, P_GREEN, 0);
        reset = 1'b1;

        // Full rotation with every approach requesting.
        wait_cycles(7);
        checkOutput("w0_green_c8", L_W0G, P_GREEN, 0);
        wait_cycles(1);
        checkOutput("w0_yellow_c1", L_W0Y, P_YELLOW, 0);
        wait_cycles(2);
        checkOutput("w0_yellow_c3", L_W0Y, P_YELLOW, 0);
        wait_cycles(1);
        checkOutput("allred", L_RED, P_ALLRED, -1);
        wait_cycles(1);
        checkOutput("w1_green", L_W1G, P_GREEN, 1);
        wait_cycles(48);

        // Single remote request skips approach 1.
        applyStimulus(4'b0100, 1'b0, 6'd8, 6'd3);
        do_reset();
        wait_cycles(7);
        checkOutput("skip_w0_green_c8", L_W0G, P_GREEN, 0);
        wait_cycles(1);
        checkOutput("skip_w0_yellow", L_W0Y, P_YELLOW, 0);
        wait_cycles(3);
        checkOutput("skip_allred", L_RED, P_ALLRED, -1);
        wait_cycles(1);
        checkOutput("skip_w2_green", L_W2G, P_GREEN, 2);
        wait_cycles(20);
        checkOutput("w2_hold_own_demand", L_W2G, P_GREEN, 2);

        // Reset during yellow of approach 2.
        applyStimulus(4'b1111, 1'b0, 6'd8, 6'd3);
        for (int i = 0; i < 40 && !(m_phase == P_YELLOW && m_way == 2); i++) wait_cycles(1);
        total++;
        if (!(m_phase == P_YELLOW && m_way == 2)) begin
            bad++;
            $display("[TB] FAIL wait_yellow_w2 got phase=%0d way=%0d want phase=1 way=2", m_phase, m_way);
        end
        wait_cycles(1);
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_yellow", L_W0G, P_GREEN, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        wait_cycles(7);
        checkOutput("post_reset_green_c8", L_W0G, P_GREEN, 0);
        wait_cycles(1);
        checkOutput("post_reset_yellow", L_W0Y, P_YELLOW, 0);

        // No demand: approach 0 holds green.
        applyStimulus(4'b0000, 1'b0, 6'd8, 6'd3);
        do_reset();
        wait_cycles(30);
        checkOutput("idle_hold_a", L_W0G, P_GREEN, 0);
        wait_cycles(30);
        checkOutput("idle_hold_b", L_W0G, P_GREEN, 0);

        // Flash requested in green cycle 5.
        applyStimulus(4'b1111, 1'b0, 6'd8, 6'd3);
        do_reset();
        wait_cycles(4);
        applyStimulus(4'b1111, 1'b1, 6'd8, 6'd3);
        wait_cycles(1);
        checkOutput("flash_on_1", L_FON, P_FLASH, -1);
        wait_cycles(3);
        checkOutput("flash_on_4", L_FON, P_FLASH, -1);
        wait_cycles(1);
        checkOutput("flash_off_1", L_OFF, P_FLASH, -1);
        wait_cycles(3);
        checkOutput("flash_off_4", L_OFF, P_FLASH, -1);
        wait_cycles(1);
        checkOutput("flash_on_again", L_FON, P_FLASH, -1);
        applyStimulus(4'b1111, 1'b0, 6'd8, 6'd3);
        wait_cycles(1);
        checkOutput("flash_exit_allred", L_RED, P_ALLRED, -1);
        wait_cycles(1);
        checkOutput("flash_exit_w0", L_W0G, P_GREEN, 0);

        // Zero green time, mid-yellow duration change, flash beating expiry.
        applyStimulus(4'b1111, 1'b0, 6'd0, 6'd3);
        do_reset();
        wait_cycles(1);
        checkOutput("g0_yellow_c1", L_W0Y, P_YELLOW, 0);
        applyStimulus(4'b1111, 1'b0, 6'd0, 6'd6);
        wait_cycles(2);
        checkOutput("g0_yellow_c3", L_W0Y, P_YELLOW, 0);
        wait_cycles(1);
        checkOutput("g0_allred", L_RED, P_ALLRED, -1);
        wait_cycles(1);
        checkOutput("g0_w1_green", L_W1G, P_GREEN, 1);
        applyStimulus(4'b1111, 1'b1, 6'd0, 6'd3);
        wait_cycles(1);
        checkOutput("flash_over_expiry", L_FON, P_FLASH, -1);
        applyStimulus(4'b1111, 1'b0, 6'd0, 6'd3);
        wait_cycles(2);
        checkOutput("g0_after_flash", L_W0G, P_GREEN, 0);
        wait_cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter N_WAY, default 4, number of approaches (2..8).
REQ-002 SHALL have parameter CNT_W, default 6, width of the phase counter and duration inputs.
REQ-003 SHALL have parameter ALLRED_T, default 1, all-red clearance duration in cycles (>=1).
REQ-004 SHALL have parameter FLASH_T, default 4, half-period of flash blinking in cycles (>=1).
REQ-005 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port demand, input, N_WAY, per-approach vehicle/pedestrian request (level).
REQ-008 SHALL have port flash_mode, input, 1, fault/night mode request (level).
REQ-009 SHALL have port green_time, input, CNT_W, green duration in cycles.
REQ-010 SHALL have port yellow_time, input, CNT_W, yellow duration in cycles.
REQ-011 SHALL have port lights, output, 3*N_WAY, approach i at bits [3i+2:3i] = {red,yellow,green}.
REQ-012 SHALL have port cur_way, output, $clog2(N_WAY), approach currently holding right-of-way.
REQ-013 SHALL have port phase, output, 2, current state: GREEN=00, YELLOW=01, ALLRED=10, FLASH=11.

Function
REQ-014 SHALL count each phase from 1; a phase of duration T SHALL last exactly T cycles, ending when count==T; count returns to 1 on every phase change.
REQ-015 SHALL sample green_time on GREEN entry and yellow_time on YELLOW entry; mid-phase input changes SHALL NOT affect the running phase; a sampled value of 0 SHALL be treated as 1.
REQ-016 GREEN: cur_way lights 001, all others 100.
REQ-017 At GREEN expiry SHALL pick next = first approach with demand set, searching round-robin cur_way+1, cur_way+2, ... excluding cur_way.
REQ-018 If a next approach exists SHALL go to YELLOW; otherwise SHALL stay GREEN on cur_way, counter restarting at 1, no yellow.
REQ-019 YELLOW: cur_way lights 010, others 100; at expiry -> ALLRED.
REQ-020 ALLRED: all lights 100 for ALLRED_T cycles; at expiry -> GREEN with cur_way = selected next approach (selection latched at GREEN expiry).
REQ-021 flash_mode high in any state SHALL force FLASH on the next edge; FLASH: all approaches 010 and 000 alternately, every FLASH_T cycles, starting with 010.
REQ-022 flash_mode low while in FLASH SHALL go to ALLRED (full ALLRED_T), then GREEN with cur_way = 0.
REQ-023 flash_mode SHALL take priority over any phase expiry in the same cycle.
REQ-024 Output lights, cur_way, phase SHALL be pure decodes of registered state (no input-to-output combinational paths).
REQ-025 Exactly one approach SHALL be non-red outside FLASH; two non-red approaches SHALL never occur.

Reset
REQ-026 reset low SHALL immediately set phase=GREEN, cur_way=0, count=1, flash toggle=on, sampled green duration=green_time at release edge semantics (register loads green_time on first cycle).
REQ-027 During and after reset lights SHALL show approach 0 = 001, all others 100; reset mid-phase SHALL abandon that phase without clearance.

Structure
REQ-028 Package traffic_pkg SHALL hold the phase encoding and light codes GREEN=3'b001, YELLOW=3'b010, RED=3'b100, OFF=3'b000.
REQ-029 Sub-module rr_next_sel SHALL implement the combinational round-robin demand search (inputs demand, cur_way; outputs found, next_way).

Verification (N_WAY=4, green_time=8, yellow_time=3, ALLRED_T=1, FLASH_T=4)
REQ-030 Reset, demand=4'b1111 -> way0 green 8 cycles, yellow 3, all-red 1, way1 green; cycle continues 1,2,3,0.
REQ-031 demand=4'b0100 during way0 green -> way0 green 8, yellow 3, all-red 1, way2 green.
REQ-032 demand=4'b0000 -> way0 stays 001 indefinitely, phase never leaves GREEN.
REQ-033 flash_mode high at green cycle 5 -> next cycle all 010 for 4 cycles, 000 for 4, repeat; deassert -> all 100 1 cycle, then way0 green.
REQ-034 reset pulsed during YELLOW of way2 -> lights immediately way0 001, others 100, count restarts at 1.
REQ-035 green_time=0, demand=4'b1111 -> each green lasts exactly 1 cycle; yellow_time changed mid-yellow -> current yellow unchanged.
